// File: rtl/instruction_sequencer.sv
// Issue stage: queues host instructions with repeat counts and drives exactly one
// word per clock to the accelerator, substituting all-zero NOPs when idle or held.
module instruction_sequencer #(
  parameter int depth    = 3,
  parameter int W        = 16,
  parameter int insW     = (2 > depth) ? 2 : depth,
  parameter int insD     = ((1 << depth) > W) ? (1 << depth) : W,
  parameter int insWidth = 4 + 2 + 2*insW + insD,
  parameter int RW       = 8,
  parameter int QA       = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                inValid,
  output logic                inReady,
  input  logic [insWidth-1:0] inInstruction,
  input  logic [RW-1:0]       inRepeat,
  input  logic                hold,
  output logic [insWidth-1:0] instruction,
  output logic                issueValid,
  output logic                idle,
  output logic [QA:0]         level
);

  typedef struct packed {
    logic [insWidth-1:0] ins;
    logic [RW-1:0]       rep;
  } entry_t;

  localparam logic [QA:0] CAP = (QA+1)'(1 << QA);

  entry_t              mem [0:(1<<QA)-1];
  logic [QA-1:0]       wrPtr, rdPtr;
  logic [RW-1:0]       remaining;
  logic [insWidth-1:0] curWord;
  entry_t              head;
  logic                push, pop;

  assign inReady = (level != CAP);
  assign idle    = (level == '0) && (remaining == '0);
  assign head    = mem[rdPtr];
  assign push    = inValid && inReady;
  // Pops only when not held and the current word has no repeats left.
  assign pop     = !hold && (remaining == '0) && (level != '0);

  always_ff @(posedge CLK) begin
    if (push && !RST) mem[wrPtr] <= '{ins: inInstruction, rep: inRepeat};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      level       <= '0;
      remaining   <= '0;
      curWord     <= '0;
      instruction <= '0;
      issueValid  <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      level <= level + {{QA{1'b0}}, push} - {{QA{1'b0}}, pop};

      // curWord survives hold so a held repeat resumes with the right word.
      if (hold) begin
        instruction <= '0;
        issueValid  <= 1'b0;
      end else if (remaining != '0) begin
        instruction <= curWord;
        issueValid  <= 1'b1;
        remaining   <= remaining - 1'b1;
      end else if (pop) begin
        curWord     <= head.ins;
        instruction <= head.ins;
        issueValid  <= 1'b1;
        remaining   <= head.rep;
      end else begin
        instruction <= '0;
        issueValid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Randomized + directed bench for instruction_sequencer against a queue-based model.
module tb_instruction_sequencer;
  localparam int IW  = 28;
  localparam int RW  = 8;
  localparam int QA  = 4;
  localparam int CAP = 1 << QA;

  logic          CLK = 0, RST = 0, inValid = 0, hold = 0;
  logic          inReady, issueValid, idle;
  logic [IW-1:0] inInstruction = '0, instruction;
  logic [RW-1:0] inRepeat = '0;
  logic [QA:0]   level;

  instruction_sequencer dut (
    .CLK(CLK), .RST(RST), .inValid(inValid), .inReady(inReady),
    .inInstruction(inInstruction), .inRepeat(inRepeat), .hold(hold),
    .instruction(instruction), .issueValid(issueValid), .idle(idle), .level(level)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [IW-1:0] ins; int rep; } ent_t;
  ent_t          q[$];
  int            rem = 0;
  logic [IW-1:0] cur = '0, expIns = '0;
  logic          expVld = 0;
  bit            known = 0;
  int            vecs = 0, errs = 0, vldCount = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Model of one clock edge: issue decisions use the pre-edge queue, then the push lands.
  task automatic modelEdge();
    bit pushOk;
    ent_t e;
    if (RST) begin
      q.delete(); rem = 0; expIns = '0; expVld = 0; known = 1;
      return;
    end
    pushOk = inValid && (q.size() < CAP);
    if (hold) begin
      expIns = '0; expVld = 0;
    end else if (rem > 0) begin
      expIns = cur; expVld = 1; rem--;
    end else if (q.size() > 0) begin
      e = q.pop_front(); cur = e.ins; rem = e.rep; expIns = e.ins; expVld = 1;
    end else begin
      expIns = '0; expVld = 0;
    end
    if (pushOk) q.push_back('{inInstruction, int'(inRepeat)});
  endtask

  task automatic tick();
    if (known) begin
      chk("level",   64'(level),   64'(q.size()));
      chk("inReady", 64'(inReady), 64'(q.size() != CAP));
      chk("idle",    64'(idle),    64'(q.size() == 0 && rem == 0));
    end
    @(posedge CLK);
    modelEdge();
    #1;
    if (known) begin
      chk("instruction", 64'(instruction), 64'(expIns));
      chk("issueValid",  64'(issueValid),  64'(expVld));
      if (issueValid) vldCount++;
    end
  endtask

  task automatic pushOne(logic [IW-1:0] ins, int rep);
    inValid = 1; inInstruction = ins; inRepeat = RW'(rep);
    tick();
    inValid = 0;
  endtask

  localparam logic [IW-1:0] A = 28'h1234567;
  localparam logic [IW-1:0] B = 28'hABCDEF0;

  initial begin
    #1;
    // 1: reset
    RST = 1; tick(); tick(); RST = 0;
    chk("rst_ins", 64'(instruction), 64'd0);
    chk("rst_vld", 64'(issueValid), 64'd0);
    chk("rst_lvl", 64'(level), 64'd0);
    chk("rst_rdy", 64'(inReady), 64'd1);
    chk("rst_idle", 64'(idle), 64'd1);

    // 2: single entry, one-cycle latency beyond the push edge
    pushOne(A, 0);
    chk("t2_noBypass", 64'(issueValid), 64'd0);
    tick();
    chk("t2_ins", 64'(instruction), 64'(A));
    chk("t2_vld", 64'(issueValid), 64'd1);
    tick();
    chk("t2_nop", 64'(issueValid), 64'd0);
    chk("t2_lvl", 64'(level), 64'd0);

    // 3: repeat followed by another entry without a gap
    pushOne(A, 3);
    pushOne(B, 0);
    vldCount = 0;
    repeat (6) tick();
    chk("t3_count", 64'(vldCount), 64'd4);

    // 4: fill while held, overflow dropped, drain in order
    hold = 1;
    for (int i = 0; i < 17; i++) pushOne(IW'(32'h0E00000 + i), 0);
    chk("t4_full", 64'(level), 64'd16);
    chk("t4_rdy", 64'(inReady), 64'd0);
    hold = 0;
    tick();
    chk("t4_rdyAfterPop", 64'(inReady), 64'd1);
    chk("t4_first", 64'(instruction), 64'(32'h0E00000));
    repeat (16) tick();

    // 5: hold in the middle of a repeat run
    pushOne(A, 5);
    vldCount = 0;
    tick(); tick();
    hold = 1; repeat (3) tick(); hold = 0;
    repeat (6) tick();
    chk("t5_count", 64'(vldCount), 64'd6);

    // 6: reset mid-repeat discards queue and repeats
    pushOne(A, 4); pushOne(B, 0); pushOne(28'h5555555, 2);
    tick();
    RST = 1; tick(); RST = 0;
    chk("t6_lvl", 64'(level), 64'd0);
    vldCount = 0;
    repeat (8) tick();
    chk("t6_noIssue", 64'(vldCount), 64'd0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      inValid       = ($urandom_range(0, 2) != 0);
      inInstruction = IW'($urandom);
      inRepeat      = RW'($urandom_range(0, 3));
      hold          = ($urandom_range(0, 7) == 0);
      RST           = ($urandom_range(0, 99) == 0);
      tick();
    end
    inValid = 0; hold = 0; RST = 0;
    repeat (70) tick();
    chk("final_idle", 64'(idle), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
